// File: rtl/regfile_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file: write port, shared read
// request, two read addresses and the registered read results.
interface regfile_2r1w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              rvalid;

    modport master (
        output we, waddr, wdata, re, raddr1, raddr2,
        input  rdata1, rdata2, rvalid
    );

    modport slave (
        input  we, waddr, wdata, re, raddr1, raddr2,
        output rdata1, rdata2, rvalid
    );
endinterface

// File: rtl/regfile_2r1w.sv
// 32x32 register file, one synchronous write port, two registered read ports.
// REGFILE_BYPASS_EN selects write-through on a same-cycle read/write collision.
module regfile_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_2r1w_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata2_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;
    logic              wr_ok;

    // Entry 0 is never written when hardwired, so it reads as its reset value.
    assign wr_ok = bus.we && !((ZERO_REG != 0) && (bus.waddr == '0));

    always_comb begin
        rd1_next = mem[bus.raddr1];
        rd2_next = mem[bus.raddr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (bus.raddr1 == bus.waddr)) rd1_next = bus.wdata;
        if (wr_ok && (bus.raddr2 == bus.waddr)) rd2_next = bus.wdata;
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (wr_ok) mem[bus.waddr] <= bus.wdata;
            rvalid_q <= bus.re;
            if (bus.re) begin
                rdata1_q <= rd1_next;
                rdata2_q <= rd2_next;
            end
        end
    end

    assign bus.rdata1 = rdata1_q;
    assign bus.rdata2 = rdata2_q;
    assign bus.rvalid = rvalid_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w.
module tb_regfile_2r1w;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        bus.we    = 1'b1;
        bus.waddr = addr;
        bus.wdata = data;
        step();
        bus.we    = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.re     = 1'b1;
        bus.we     = 1'b1;
        bus.waddr  = 5'd3;
        bus.wdata  = 32'hFFFF_FFFF;
        bus.raddr1 = 5'd3;
        bus.raddr2 = 5'd0;
        step();
        step();
        checks++;
        if (bus.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid);
        end
        checks++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.rdata1, bus.rdata2);
        end
        rst    = 1'b0;
        bus.we = 1'b0;
        step();
        checks++;
        if (bus.rvalid !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_read_rvalid got=%b exp=1", bus.rvalid);
        end
        checks++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_write_blocked got=%h/%h exp=0/0", bus.rdata1, bus.rdata2);
        end
        bus.re = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'h0000_1FFF);
        do_write(5'd31, 32'h001F_FF00);
        bus.re     = 1'b1;
        bus.raddr1 = 5'd5;
        bus.raddr2 = 5'd31;
        step();
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata1 !== 32'h0000_1FFF || bus.rdata2 !== 32'h001F_FF00) begin
            failures++;
            $display("FAIL write_read got=%b %h %h exp=1 00001fff 001fff00",
                     bus.rvalid, bus.rdata1, bus.rdata2);
        end
        bus.re     = 1'b0;
        bus.raddr1 = 5'd0;
        bus.raddr2 = 5'd0;
        step();
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rdata1 !== 32'h0000_1FFF || bus.rdata2 !== 32'h001F_FF00) begin
            failures++;
            $display("FAIL read_hold got=%b %h %h exp=0 00001fff 001fff00",
                     bus.rvalid, bus.rdata1, bus.rdata2);
        end
    endtask

    task automatic test_zero_reg();
        do_write(5'd0, 32'h07E0_0000);
        bus.re     = 1'b1;
        bus.raddr1 = 5'd0;
        bus.raddr2 = 5'd0;
        step();
        bus.re = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            failures++;
            $display("FAIL zero_reg got=%b %h %h exp=1 0 0", bus.rvalid, bus.rdata1, bus.rdata2);
        end
        step();
    endtask

    task automatic test_collision();
        logic [31:0] exp1;
        do_write(5'd7, 32'h0000_0000);
        bus.we     = 1'b1;
        bus.waddr  = 5'd7;
        bus.wdata  = 32'h0000_07F0;
        bus.re     = 1'b1;
        bus.raddr1 = 5'd7;
        bus.raddr2 = 5'd5;
        step();
        bus.we = 1'b0;
`ifdef REGFILE_BYPASS_EN
        exp1 = 32'h0000_07F0;
`else
        exp1 = 32'h0000_0000;
`endif
        checks++;
        if (bus.rdata1 !== exp1) begin
            failures++;
            $display("FAIL collision_port1 got=%h exp=%h", bus.rdata1, exp1);
        end
        checks++;
        if (bus.rdata2 !== 32'h0000_1FFF) begin
            failures++;
            $display("FAIL collision_port2_unaffected got=%h exp=00001fff", bus.rdata2);
        end
        bus.raddr2 = 5'd7;
        step();
        bus.re = 1'b0;
        checks++;
        if (bus.rdata1 !== 32'h0000_07F0 || bus.rdata2 !== 32'h0000_07F0) begin
            failures++;
            $display("FAIL collision_followup got=%h/%h exp=000007f0/000007f0", bus.rdata1, bus.rdata2);
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) do_write(5'(i), 32'(i) * 32'h11);
        bus.re = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.raddr1 = 5'(i);
            bus.raddr2 = 5'(9 - i);
            step();
            checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata1 !== 32'(i) * 32'h11
                || bus.rdata2 !== 32'(9 - i) * 32'h11) begin
                failures++;
                $display("FAIL stream_%0d got=%b %h %h exp=1 %h %h", i, bus.rvalid,
                         bus.rdata1, bus.rdata2, 32'(i) * 32'h11, 32'(9 - i) * 32'h11);
            end
        end
        bus.re = 1'b0;
        step();
        checks++;
        if (bus.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL stream_end_rvalid got=%b exp=0", bus.rvalid);
        end
    endtask

    task automatic test_reset_mid_read();
        bus.re     = 1'b1;
        bus.raddr1 = 5'd5;
        bus.raddr2 = 5'd31;
        step();
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata1 !== 32'h55 || bus.rdata2 !== 32'h001F_FF00) begin
            failures++;
            $display("FAIL pre_reset_read got=%b %h %h exp=1 00000055 001fff00",
                     bus.rvalid, bus.rdata1, bus.rdata2);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
            failures++;
            $display("FAIL mid_read_reset got=%b %h %h exp=0 0 0", bus.rvalid, bus.rdata1, bus.rdata2);
        end
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            bus.raddr1 = 5'(i);
            bus.raddr2 = 5'(32 - i);
            step();
            checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
                failures++;
                $display("FAIL cleared_entry_%0d got=%b %h %h exp=1 0 0", i,
                         bus.rvalid, bus.rdata1, bus.rdata2);
            end
        end
        bus.re = 1'b0;
        step();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus.we     = 1'b0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        bus.re     = 1'b0;
        bus.raddr1 = '0;
        bus.raddr2 = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_collision();
        test_back_to_back();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
